pc_predict_gen: RTL
===================

// Module: pc_predict_gen
// PURPOSE
//  Next-generation fetch PC generator. Holds pc_o and picks the next fetch PC each cycle.
//  Prediction uses a tagged BTB, an N-bit saturating BHT and a circular return-address stack (RAS).
//  Sits between EX/branch-resolve (redirect and update feedback) and IF (fetch PC).
//  Relative to the earlier PC reg, it adds: parametrised table geometry, per-entry valid bits,
//  entry type (branch/jump/call/ret), RAS-based return prediction and a pred_taken_o tag to IF.
// PARAMETERS
//  ADDR_W    32      PC width
//  IDX_W     7       BTB/BHT index bits, taken from pc[IDX_W+1:2]; 2**IDX_W entries
//  TAG_W     9       tag bits, taken from pc[IDX_W+TAG_W+1:IDX_W+2]
//  CTR_W     2       saturating counter width; predict taken when counter MSB = 1
//  RAS_DEPTH 4       RAS entries; must be a power of two, >= 2
//  RESET_PC  32'h0   pc_o value after reset
// PORTS
//  clk              in   1       clock
//  rst              in   1       reset; asynchronous, active-low (0 = reset)
//  rdy              in   1       global ready; when 0, no state changes (tables, RAS, pc_o all hold)
//  stall_i          in   1       pipeline stall; holds pc_o and RAS
//  fetch_ack_i      in   1       IF has consumed pc_o this cycle (icache hit or memory return)
//  redirect_i       in   1       mispredict or flush; load redirect_pc_i
//  redirect_pc_i    in   ADDR_W  corrected PC
//  upd_valid_i      in   1       a resolved jal/jalr/branch is reported this cycle
//  upd_pc_i         in   ADDR_W  PC of the resolved instruction
//  upd_target_i     in   ADDR_W  resolved target
//  upd_taken_i      in   1       resolved direction
//  upd_type_i       in   2       00 cond branch, 01 jump, 10 call, 11 return
//  pc_o             out  ADDR_W  current fetch PC
//  pred_taken_o     out  1       registered; the prediction that produced pc_o
//  pc_jump_enable_o out  1       combinational; 1 in any cycle where pc_o loads redirect_pc_i
// BEHAVIOUR
//  Reset (async, rst=0): pc_o=RESET_PC, pred_taken_o=0, all valid bits=0,
//   all counters=2**(CTR_W-1)-1 (weakly not-taken), RAS ptr=0, RAS count=0. BTB target and tag RAM are not reset.
//  Lookup is combinational on pc_o. hit = valid[idx] && tag[idx]==pc_o tag field.
//   type 00 with counter MSB=1: next = btb_target.
//   type 01 or 10: always taken; next = btb_target.
//   type 11 with RAS count>0: next = RAS top. With RAS empty: next = btb_target.
//   Miss, or type 00 with counter MSB=0: next = pc_o+4, with modulo-2**ADDR_W wrap.
//  Per-cycle priority when rdy=1:
//   1) redirect_i=1 and (fetch_ack_i=1 or no fetch outstanding): pc_o<=redirect_pc_i, pred_taken_o<=0,
//      pc_jump_enable_o=1. RAS is unchanged (no checkpoint).
//   2) Else, if stall_i=0 and fetch_ack_i=1: pc_o<=next, pred_taken_o<=(next!=pc_o+4).
//      Hit of type call: push pc_o+4. Hit of type return: pop.
//   3) Else: hold.
//  "No fetch outstanding" is an input condition: fetch_ack_i=0 and IF not mid-access. IF signals this by asserting
//   fetch_ack_i; the block treats redirect with fetch_ack_i=0 as immediately legal. It does not track IF state.
//  RAS: circular. Push when full overwrites the oldest entry; count saturates at RAS_DEPTH. Pop when empty is a
//   no-op; count stays 0.
//  Update (upd_valid_i=1, rdy=1): write target, tag, type, valid=1 at upd idx.
//   Counter: taken and below max -> +1; not taken and above 0 -> -1; otherwise saturates.
//   Tag mismatch on an existing valid entry: re-initialise the counter to weak state, then apply this outcome.
//  Update and lookup at the same idx in one cycle: lookup sees the pre-update contents (read-before-write).
//  Reset asserted mid-fetch: immediate return to reset values; the in-flight fetch is discarded by IF.
// STRUCTURE
//  Shared package/defines: ADDR_W, branch-type encodings (BR_COND, BR_JUMP, BR_CALL, BR_RET), Enable/Disable, ZERO_WORD.
//  One sub-module: pc_ras (push/pop/top/count, RAS_DEPTH param). BTB/BHT stay inline as register arrays.
// TESTING
//  1 Reset: rst=0 mid-run, async -> pc_o=0, pred_taken_o=0; sequential fetch_ack -> 0,4,8.
//  2 Branch training: update pc=0x40 tgt=0x100 taken x2 -> at pc 0x40 next=0x100, pred_taken_o=1; two not-taken -> 0x44.
//  3 Alias: update 0x40, then fetch at 0x40+(1<<(IDX_W+2)) -> tag miss, next=pc+4.
//  4 Call/ret: call at 0x200 tgt 0x800, ret at 0x804 trained -> fetch 0x200,0x800,0x804,0x204.
//  5 RAS overflow: RAS_DEPTH+1 nested calls then returns -> last return falls back to btb_target; underflow pop is a no-op.
//  6 Collisions: redirect+stall+ack same cycle -> redirect wins, pc_jump_enable_o=1.
//    rdy=0 -> full hold.
//    Update and lookup at same idx -> old prediction used.

Source files
------------

// File: rtl/pc_predict_gen_pkg.sv
// Shared definitions for the fetch PC generator: branch-type encodings and common constants.
package pc_predict_gen_pkg;

    localparam int ADDR_W_DEF = 32;

    typedef enum logic [1:0] {
        BR_COND = 2'b00,
        BR_JUMP = 2'b01,
        BR_CALL = 2'b10,
        BR_RET  = 2'b11
    } br_type_e;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [ADDR_W_DEF-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push when full overwrites the oldest entry; a pop when empty does nothing.
module pc_ras
    import pc_predict_gen_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             push_data,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] stack_q;
    logic [PW-1:0]           ptr_q;
    logic [PW:0]             count_q;

    // ptr_q is the next free slot; wrapping it is what makes overflow drop the oldest entry
    assign top   = stack_q[ptr_q - 1'b1];
    assign count = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else if (push) begin
            ptr_q <= ptr_q + 1'b1;
            if (count_q != DEPTH[PW:0])
                count_q <= count_q + 1'b1;
        end else if (pop && count_q != '0) begin
            ptr_q   <= ptr_q - 1'b1;
            count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            stack_q[ptr_q] <= push_data;
    end

endmodule

// File: rtl/pc_predict_gen.sv
// Fetch PC generator: tagged BTB + saturating BHT + return-address stack pick the next fetch PC each cycle.
module pc_predict_gen
    import pc_predict_gen_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                IDX_W     = 7,
    parameter int                TAG_W     = 9,
    parameter int                CTR_W     = 2,
    parameter int                RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              stall_i,
    input  logic              fetch_ack_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_taken_i,
    input  logic [1:0]        upd_type_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pred_taken_o,
    output logic              pc_jump_enable_o
);

    localparam int               ENTRIES  = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;

    logic [ENTRIES-1:0]             valid_q;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag_q;
    logic [ENTRIES-1:0][ADDR_W-1:0] tgt_q;
    logic [ENTRIES-1:0][1:0]        type_q;
    logic [ENTRIES-1:0][CTR_W-1:0]  ctr_q;

    logic [ADDR_W-1:0] pc_q;
    logic              pred_q;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit;
    br_type_e          hit_type;
    logic [ADDR_W-1:0] hit_tgt;
    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] next_pc;

    logic                      redirect_fire;
    logic                      advance;
    logic                      ras_push;
    logic                      ras_pop;
    logic [ADDR_W-1:0]         ras_top;
    logic [$clog2(RAS_DEPTH):0] ras_count;

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic [CTR_W-1:0] ctr_base;
    logic [CTR_W-1:0] ctr_new;

    // -------------------------------------------------------------- lookup
    assign idx      = pc_q[IDX_W+1:2];
    assign tag      = pc_q[IDX_W+TAG_W+1:IDX_W+2];
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);
    assign hit_type = br_type_e'(type_q[idx]);
    assign hit_tgt  = tgt_q[idx];
    assign pc_seq   = pc_q + ADDR_W'(4);

    always_comb begin
        next_pc = pc_seq;
        if (hit) begin
            case (hit_type)
                BR_COND: if (ctr_q[idx][CTR_W-1]) next_pc = hit_tgt;
                BR_JUMP,
                BR_CALL: next_pc = hit_tgt;
                BR_RET:  next_pc = (ras_count != '0) ? ras_top : hit_tgt;
                default: next_pc = pc_seq;
            endcase
        end
    end

    // -------------------------------------------------------------- PC control
    // A redirect is taken whether or not IF acks: IF only raises it when the redirect is safe.
    assign redirect_fire    = rdy & redirect_i;
    assign advance          = rdy & ~redirect_i & ~stall_i & fetch_ack_i;
    assign pc_jump_enable_o = redirect_fire;

    assign ras_push = advance & hit & (hit_type == BR_CALL);
    assign ras_pop  = advance & hit & (hit_type == BR_RET);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= RESET_PC;
            pred_q <= DISABLE;
        end else if (redirect_fire) begin
            pc_q   <= redirect_pc_i;
            pred_q <= DISABLE;
        end else if (advance) begin
            pc_q   <= next_pc;
            pred_q <= (next_pc != pc_seq);
        end
    end

    assign pc_o         = pc_q;
    assign pred_taken_o = pred_q;

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_seq),
        .top       (ras_top),
        .count     (ras_count)
    );

    // -------------------------------------------------------------- table update
    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

    // A different branch taking over a slot must not inherit the old owner's history
    always_comb begin
        ctr_base = ctr_q[upd_idx];
        if (valid_q[upd_idx] && (tag_q[upd_idx] != upd_tag))
            ctr_base = CTR_WEAK;
        ctr_new = ctr_base;
        if (upd_taken_i) begin
            if (ctr_base != CTR_MAX)
                ctr_new = ctr_base + 1'b1;
        end else if (ctr_base != '0) begin
            ctr_new = ctr_base - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            ctr_q   <= {ENTRIES{CTR_WEAK}};
        end else if (rdy && upd_valid_i) begin
            valid_q[upd_idx] <= ENABLE;
            ctr_q[upd_idx]   <= ctr_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && upd_valid_i) begin
            tag_q[upd_idx]  <= upd_tag;
            tgt_q[upd_idx]  <= upd_target_i;
            type_q[upd_idx] <= upd_type_i;
        end
    end

    logic unused_upd_bits;
    assign unused_upd_bits = ^{upd_pc_i[1:0], upd_pc_i[ADDR_W-1:IDX_W+TAG_W+2]};

endmodule
